roce_write_segmenter: RTL and testbench
=======================================

# roce_write_segmenter

Splits one RDMA WRITE DMA request into PMTU-sized RoCEv2 RC packets and emits one header descriptor per packet. Sits directly downstream of the UDP RoCE connection manager, which supplies the QP parameters, remote address and `start_transfer` pulse. Feeds the RoCE TX header/payload assembler. Produces headers only; payload bytes are carried by a separate path using `m_roce_payload_length`.

## Interface
- `PMTU_BYTES`, 1024: path MTU in bytes; power of two in 256..4096.
- `DEST_UDP_PORT`, 16'd4791: value driven on `m_udp_dest_port`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_transfer` in 1: one-cycle request pulse.
- `metadata_valid` in 1: request fields valid; qualifies `start_transfer`.
- `dma_length` in 32: total bytes to write.
- `rem_addr` in 64: remote virtual address.
- `r_key` in 32: remote key.
- `rem_qpn` in 24: destination QP.
- `start_psn` in 24: PSN of the first packet.
- `rem_ip_addr` in 32: destination IP.
- `m_roce_bth_valid` out 1 / `m_roce_bth_ready` in 1: header handshake.
- `m_roce_bth_op_code` out 8: BTH opcode.
- `m_roce_bth_psn` out 24: packet PSN.
- `m_roce_bth_dest_qp` out 24: destination QP.
- `m_roce_bth_ack_req` out 1: BTH A bit.
- `m_roce_reth_v` out 1: RETH present.
- `m_roce_reth_vaddr` out 64, `m_roce_reth_r_key` out 32, `m_roce_reth_length` out 32: RETH fields.
- `m_roce_payload_length` out 16: payload bytes in this packet.
- `m_ip_dest_ip` out 32: destination IP.
- `m_udp_dest_port` out 16: destination UDP port.
- `next_psn` out 24: PSN following the last packet emitted.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse when the last header is accepted.

## Operation
- States: IDLE, SEND.
- IDLE:
  - On `start_transfer && metadata_valid`, latch all request fields and go to SEND.
  - Set `remaining = dma_length` and `psn = start_psn`.
  - Set `first = 1`.
- SEND:
  - Present the header for the current packet.
  - On handshake (`valid && ready`):
    - `remaining -= payload_length`.
    - `psn = psn + 1` mod 2^24.
    - `first = 0`.
  - After the last packet's handshake, pulse `done`, update `next_psn`, return to IDLE.
- Packet count: `ceil(dma_length / PMTU_BYTES)`. A length of 0 gives one packet.
- Opcode per packet:
  - Only packet: ONLY 0x0A.
  - First of several: FIRST 0x06.
  - Interior: MIDDLE 0x07.
  - Final: LAST 0x08.
- Payload length: `min(remaining, PMTU_BYTES)`. Only the final packet may be short. A zero-length request gives payload 0.
- RETH:
  - `m_roce_reth_v = 1` on FIRST/ONLY only.
  - Fields: vaddr = latched `rem_addr`, length = latched `dma_length`, `r_key` = latched `r_key`.
  - When `reth_v = 0`, the RETH fields read 0.
- `ack_req = 1` on LAST/ONLY only.
- `dest_qp`, `dest_ip` and UDP port are constant for the whole transfer.
- `start_transfer` while `busy` is ignored; no queueing.
- Input changes after the latch have no effect on the transfer in progress.

## Timing
- Reset values: all outputs 0, including `busy`, `done`, `valid` and `next_psn`. State returns to IDLE.
- Reset mid-transfer:
  - The transfer is abandoned.
  - `valid` is 0 in the cycle after `rst` is sampled.
  - No further headers are emitted and `done` does not pulse.
- Request accepted at cycle N:
  - `m_roce_bth_valid` and `busy` go high at N+1.
  - The first header is valid at N+1.
- Handshake:
  - `valid` never depends on `ready`.
  - While `valid && !ready`, all `m_*` fields are held stable.
- Throughput: one header per cycle when `ready` is held high. The next header is registered in the same cycle as the current handshake, so `valid` stays high between packets.
- End of transfer: final handshake at cycle M gives `done = 1`, `valid = 0`, `busy = 0` and new `next_psn` at M+1.
- Back-to-back transfers: a new request can be accepted at M+1, with its first header at M+2.
- Widths: `remaining` is 32-bit unsigned, with no wrap because subtraction never exceeds `remaining`. PSN wraps 0xFFFFFF to 0x000000.

## Configuration
- `ROCE_SEG_IMMDT_EN` defined:
  - Adds port `imm_data` (in 32), latched with the request.
  - Adds `m_roce_immdh_v` (out 1) and `m_roce_immdh_data` (out 32).
  - Final packet uses LAST_WITH_IMM 0x09 / ONLY_WITH_IMM 0x0B.
  - `immdh_v = 1` and data = latched `imm_data` on the final packet only; 0 otherwise.
- `ROCE_SEG_IMMDT_EN` undefined: these ports are absent, and opcodes 0x09/0x0B are never produced.

## Test plan
- `dma_length = 0`, `start_psn = 0x10` → one header:
  - op 0x0A, payload 0, `reth_v = 1`, `reth_length = 0`, `ack_req = 1`, psn 0x10.
  - `next_psn = 0x11`.
- `dma_length = 1024`, PMTU 1024 → one header: op 0x0A, payload 1024, `ack_req = 1`.
- `dma_length = 2500`, `rem_addr = 0x1000`, psn P, `ready = 1` → headers on consecutive cycles:
  - 0x06 / 1024 / P, RETH vaddr 0x1000, length 2500.
  - 0x07 / 1024 / P+1, `reth_v = 0`.
  - 0x08 / 452 / P+2, `ack_req = 1`.
  - `done` one cycle after the last handshake.
- `start_psn = 0xFFFFFF`, `dma_length = 2048` → FIRST psn 0xFFFFFF, LAST psn 0x000000, `next_psn = 0x000001`.
- Random `ready` backpressure on the 2500-byte case, plus a `start_transfer` pulse mid-transfer:
  - Fields are stable while stalled.
  - The extra start is ignored; exactly 3 headers are emitted.
- `rst` asserted after the FIRST handshake → `valid`/`busy` are 0 the next cycle, with no further headers and no `done`.
- With `ROCE_SEG_IMMDT_EN`, `dma_length = 2500`, `imm_data = 0xCAFEF00D` → final op 0x09, `immdh_v = 1`, data 0xCAFEF00D; `immdh_v = 0` on packets 1–2.

Source files
------------

// File: rtl/roce_write_segmenter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | roce_write_segmenter                                                     |
// | Splits one RDMA WRITE request into PMTU-sized RoCEv2 RC header           |
// | descriptors. Optional macro ROCE_SEG_IMMDT_EN adds WRITE-with-immediate. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module roce_write_segmenter #(
  parameter int          PMTU_BYTES    = 1024,
  parameter logic [15:0] DEST_UDP_PORT = 16'd4791
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_transfer,
  input  logic        metadata_valid,
  input  logic [31:0] dma_length,
  input  logic [63:0] rem_addr,
  input  logic [31:0] r_key,
  input  logic [23:0] rem_qpn,
  input  logic [23:0] start_psn,
  input  logic [31:0] rem_ip_addr,
`ifdef ROCE_SEG_IMMDT_EN
  input  logic [31:0] imm_data,
  output logic        m_roce_immdh_v,
  output logic [31:0] m_roce_immdh_data,
`endif
  output logic        m_roce_bth_valid,
  input  logic        m_roce_bth_ready,
  output logic [7:0]  m_roce_bth_op_code,
  output logic [23:0] m_roce_bth_psn,
  output logic [23:0] m_roce_bth_dest_qp,
  output logic        m_roce_bth_ack_req,
  output logic        m_roce_reth_v,
  output logic [63:0] m_roce_reth_vaddr,
  output logic [31:0] m_roce_reth_r_key,
  output logic [31:0] m_roce_reth_length,
  output logic [15:0] m_roce_payload_length,
  output logic [31:0] m_ip_dest_ip,
  output logic [15:0] m_udp_dest_port,
  output logic [23:0] next_psn,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] c_pmtu = 32'(PMTU_BYTES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_rem;   // bytes left, including the packet currently presented

  logic        w_accept;
  logic        w_hs;
  logic        w_first;
  logic        w_last;
  logic [31:0] w_rem;
  logic [15:0] w_pay;
  logic [7:0]  w_op;
  logic [63:0] w_vaddr;
  logic [31:0] w_rkey;
  logic [31:0] w_len;
`ifdef ROCE_SEG_IMMDT_EN
  logic [31:0] r_imm;
  logic [31:0] w_imm;
`endif

  // Header for the next packet: built from the request on accept, otherwise
  // from the remaining count after the current packet is consumed.
  always_comb begin
    w_accept = (r_state == ST_IDLE) && start_transfer && metadata_valid;
    w_hs     = (r_state == ST_SEND) && m_roce_bth_valid && m_roce_bth_ready;
    w_first  = (r_state == ST_IDLE);
    w_rem    = w_first ? dma_length : (r_rem - c_pmtu);
    w_last   = (w_rem <= c_pmtu);
    w_pay    = w_last ? w_rem[15:0] : c_pmtu[15:0];
`ifdef ROCE_SEG_IMMDT_EN
    if (w_first && w_last)  w_op = 8'h0B;
    else if (w_first)       w_op = 8'h06;
    else if (w_last)        w_op = 8'h09;
    else                    w_op = 8'h07;
    w_imm    = w_last ? (w_first ? imm_data : r_imm) : 32'd0;
`else
    if (w_first && w_last)  w_op = 8'h0A;
    else if (w_first)       w_op = 8'h06;
    else if (w_last)        w_op = 8'h08;
    else                    w_op = 8'h07;
`endif
    w_vaddr  = w_first ? rem_addr   : 64'd0;
    w_rkey   = w_first ? r_key      : 32'd0;
    w_len    = w_first ? dma_length : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state               <= ST_IDLE;
      r_rem                 <= 32'd0;
      m_roce_bth_valid      <= 1'b0;
      m_roce_bth_op_code    <= 8'd0;
      m_roce_bth_psn        <= 24'd0;
      m_roce_bth_dest_qp    <= 24'd0;
      m_roce_bth_ack_req    <= 1'b0;
      m_roce_reth_v         <= 1'b0;
      m_roce_reth_vaddr     <= 64'd0;
      m_roce_reth_r_key     <= 32'd0;
      m_roce_reth_length    <= 32'd0;
      m_roce_payload_length <= 16'd0;
      m_ip_dest_ip          <= 32'd0;
      m_udp_dest_port       <= 16'd0;
      next_psn              <= 24'd0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
`ifdef ROCE_SEG_IMMDT_EN
      r_imm                 <= 32'd0;
      m_roce_immdh_v        <= 1'b0;
      m_roce_immdh_data     <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      if (w_accept || (w_hs && !m_roce_bth_ack_req)) begin
        r_rem                 <= w_rem;
        m_roce_bth_op_code    <= w_op;
        m_roce_bth_ack_req    <= w_last;
        m_roce_reth_v         <= w_first;
        m_roce_reth_vaddr     <= w_vaddr;
        m_roce_reth_r_key     <= w_rkey;
        m_roce_reth_length    <= w_len;
        m_roce_payload_length <= w_pay;
`ifdef ROCE_SEG_IMMDT_EN
        m_roce_immdh_v        <= w_last;
        m_roce_immdh_data     <= w_imm;
`endif
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state            <= ST_SEND;
            m_roce_bth_valid   <= 1'b1;
            busy               <= 1'b1;
            m_roce_bth_psn     <= start_psn;
            m_roce_bth_dest_qp <= rem_qpn;
            m_ip_dest_ip       <= rem_ip_addr;
            m_udp_dest_port    <= DEST_UDP_PORT;
`ifdef ROCE_SEG_IMMDT_EN
            r_imm              <= imm_data;
`endif
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            // ack_req marks the final packet of the transfer
            if (m_roce_bth_ack_req) begin
              r_state          <= ST_IDLE;
              m_roce_bth_valid <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              next_psn         <= m_roce_bth_psn + 24'd1;
            end else begin
              m_roce_bth_psn   <= m_roce_bth_psn + 24'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_roce_write_segmenter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_roce_write_segmenter                                                  |
// | Directed self-checking bench for roce_write_segmenter.                   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_roce_write_segmenter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_transfer;
  logic        metadata_valid;
  logic [31:0] dma_length;
  logic [63:0] rem_addr;
  logic [31:0] r_key;
  logic [23:0] rem_qpn;
  logic [23:0] start_psn;
  logic [31:0] rem_ip_addr;
  logic        m_roce_bth_valid;
  logic        m_roce_bth_ready;
  logic [7:0]  m_roce_bth_op_code;
  logic [23:0] m_roce_bth_psn;
  logic [23:0] m_roce_bth_dest_qp;
  logic        m_roce_bth_ack_req;
  logic        m_roce_reth_v;
  logic [63:0] m_roce_reth_vaddr;
  logic [31:0] m_roce_reth_r_key;
  logic [31:0] m_roce_reth_length;
  logic [15:0] m_roce_payload_length;
  logic [31:0] m_ip_dest_ip;
  logic [15:0] m_udp_dest_port;
  logic [23:0] next_psn;
  logic        busy;
  logic        done;
`ifdef ROCE_SEG_IMMDT_EN
  logic [31:0] imm_data;
  logic        m_roce_immdh_v;
  logic [31:0] m_roce_immdh_data;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int hs_cnt     = 0;
  int done_cnt   = 0;
  int hs_base;
  int done_base;

  always #5 clk = ~clk;

  roce_write_segmenter #(.PMTU_BYTES(1024), .DEST_UDP_PORT(16'd4791)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_transfer        (start_transfer),
    .metadata_valid        (metadata_valid),
    .dma_length            (dma_length),
    .rem_addr              (rem_addr),
    .r_key                 (r_key),
    .rem_qpn               (rem_qpn),
    .start_psn             (start_psn),
    .rem_ip_addr           (rem_ip_addr),
`ifdef ROCE_SEG_IMMDT_EN
    .imm_data              (imm_data),
    .m_roce_immdh_v        (m_roce_immdh_v),
    .m_roce_immdh_data     (m_roce_immdh_data),
`endif
    .m_roce_bth_valid      (m_roce_bth_valid),
    .m_roce_bth_ready      (m_roce_bth_ready),
    .m_roce_bth_op_code    (m_roce_bth_op_code),
    .m_roce_bth_psn        (m_roce_bth_psn),
    .m_roce_bth_dest_qp    (m_roce_bth_dest_qp),
    .m_roce_bth_ack_req    (m_roce_bth_ack_req),
    .m_roce_reth_v         (m_roce_reth_v),
    .m_roce_reth_vaddr     (m_roce_reth_vaddr),
    .m_roce_reth_r_key     (m_roce_reth_r_key),
    .m_roce_reth_length    (m_roce_reth_length),
    .m_roce_payload_length (m_roce_payload_length),
    .m_ip_dest_ip          (m_ip_dest_ip),
    .m_udp_dest_port       (m_udp_dest_port),
    .next_psn              (next_psn),
    .busy                  (busy),
    .done                  (done)
  );

  always @(posedge clk) begin
    if (!rst && m_roce_bth_valid && m_roce_bth_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] len, input logic [23:0] psn, input logic [63:0] addr);
    start_transfer = 1'b1;
    metadata_valid = 1'b1;
    dma_length     = len;
    start_psn      = psn;
    rem_addr       = addr;
    tick();
    start_transfer = 1'b0;
    metadata_valid = 1'b0;
  endtask

  task automatic hdr(input string tag, input logic [7:0] op, input logic [15:0] pay,
                     input logic [23:0] psn, input logic reth_v, input logic ack);
    chk({tag, "_valid"}, m_roce_bth_valid, 1'b1);
    chk({tag, "_op"},    m_roce_bth_op_code, op);
    chk({tag, "_pay"},   m_roce_payload_length, pay);
    chk({tag, "_psn"},   m_roce_bth_psn, psn);
    chk({tag, "_rethv"}, m_roce_reth_v, reth_v);
    chk({tag, "_ack"},   m_roce_bth_ack_req, ack);
  endtask

  initial begin
    rst = 1'b1; start_transfer = 1'b0; metadata_valid = 1'b0;
    dma_length = 32'd0; rem_addr = 64'd0; r_key = 32'h1234_5678;
    rem_qpn = 24'hABCDEF; start_psn = 24'd0; rem_ip_addr = 32'hC0A8_0001;
    m_roce_bth_ready = 1'b1;
`ifdef ROCE_SEG_IMMDT_EN
    imm_data = 32'd0;
`endif
    tick(); tick();
    chk("rst_valid", m_roce_bth_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_next_psn", next_psn, 24'd0);
    chk("rst_port", m_udp_dest_port, 16'd0);
    rst = 1'b0;
    tick();

    // zero-length request: single ONLY header with empty payload
    req(32'd0, 24'h10, 64'h55);
    chk("z_busy", busy, 1'b1);
`ifdef ROCE_SEG_IMMDT_EN
    hdr("z", 8'h0B, 16'd0, 24'h10, 1'b1, 1'b1);
`else
    hdr("z", 8'h0A, 16'd0, 24'h10, 1'b1, 1'b1);
`endif
    chk("z_rethlen", m_roce_reth_length, 32'd0);
    chk("z_vaddr", m_roce_reth_vaddr, 64'h55);
    tick();
    chk("z_done", done, 1'b1);
    chk("z_valid_off", m_roce_bth_valid, 1'b0);
    chk("z_busy_off", busy, 1'b0);
    chk("z_next_psn", next_psn, 24'h11);

    // exactly one PMTU, issued back-to-back with the previous completion
    req(32'd1024, 24'h20, 64'h0);
`ifdef ROCE_SEG_IMMDT_EN
    hdr("one", 8'h0B, 16'd1024, 24'h20, 1'b1, 1'b1);
`else
    hdr("one", 8'h0A, 16'd1024, 24'h20, 1'b1, 1'b1);
`endif
    tick();
    chk("one_done", done, 1'b1);
    chk("one_next_psn", next_psn, 24'h21);
    tick();
    chk("one_done_pulse", done, 1'b0);

    // 2500 bytes, ready held high: FIRST/MIDDLE/LAST on consecutive cycles
    req(32'd2500, 24'h100, 64'h1000);
    hdr("m1", 8'h06, 16'd1024, 24'h100, 1'b1, 1'b0);
    chk("m1_vaddr", m_roce_reth_vaddr, 64'h1000);
    chk("m1_len", m_roce_reth_length, 32'd2500);
    chk("m1_rkey", m_roce_reth_r_key, 32'h1234_5678);
    chk("m1_qp", m_roce_bth_dest_qp, 24'hABCDEF);
    chk("m1_ip", m_ip_dest_ip, 32'hC0A8_0001);
    chk("m1_port", m_udp_dest_port, 16'd4791);
    tick();
    hdr("m2", 8'h07, 16'd1024, 24'h101, 1'b0, 1'b0);
    chk("m2_vaddr", m_roce_reth_vaddr, 64'h0);
    chk("m2_len", m_roce_reth_length, 32'd0);
    tick();
`ifdef ROCE_SEG_IMMDT_EN
    hdr("m3", 8'h09, 16'd452, 24'h102, 1'b0, 1'b1);
`else
    hdr("m3", 8'h08, 16'd452, 24'h102, 1'b0, 1'b1);
`endif
    chk("m3_done_early", done, 1'b0);
    tick();
    chk("m_done", done, 1'b1);
    chk("m_next_psn", next_psn, 24'h103);
    tick();

    // PSN wrap across the 24-bit boundary
    req(32'd2048, 24'hFFFFFF, 64'h0);
    hdr("w1", 8'h06, 16'd1024, 24'hFFFFFF, 1'b1, 1'b0);
    tick();
`ifdef ROCE_SEG_IMMDT_EN
    hdr("w2", 8'h09, 16'd1024, 24'h000000, 1'b0, 1'b1);
`else
    hdr("w2", 8'h08, 16'd1024, 24'h000000, 1'b0, 1'b1);
`endif
    tick();
    chk("w_next_psn", next_psn, 24'h000001);
    tick();

    // backpressure, input churn after latch and an ignored mid-transfer start
    hs_base = hs_cnt;
    m_roce_bth_ready = 1'b0;
    req(32'd2500, 24'h200, 64'h1000);
    dma_length = 32'd9999; rem_addr = 64'hDEAD; start_psn = 24'h777;
    hdr("b1", 8'h06, 16'd1024, 24'h200, 1'b1, 1'b0);
    tick();
    start_transfer = 1'b1; metadata_valid = 1'b1;
    tick();
    start_transfer = 1'b0; metadata_valid = 1'b0;
    hdr("b1s", 8'h06, 16'd1024, 24'h200, 1'b1, 1'b0);
    chk("b1s_vaddr", m_roce_reth_vaddr, 64'h1000);
    chk("b1s_len", m_roce_reth_length, 32'd2500);
    m_roce_bth_ready = 1'b1;
    tick();
    m_roce_bth_ready = 1'b0;
    hdr("b2", 8'h07, 16'd1024, 24'h201, 1'b0, 1'b0);
    start_transfer = 1'b1; metadata_valid = 1'b1;
    tick();
    start_transfer = 1'b0; metadata_valid = 1'b0;
    hdr("b2s", 8'h07, 16'd1024, 24'h201, 1'b0, 1'b0);
    m_roce_bth_ready = 1'b1;
    tick();
`ifdef ROCE_SEG_IMMDT_EN
    hdr("b3", 8'h09, 16'd452, 24'h202, 1'b0, 1'b1);
`else
    hdr("b3", 8'h08, 16'd452, 24'h202, 1'b0, 1'b1);
`endif
    tick();
    chk("b_done", done, 1'b1);
    chk("b_next_psn", next_psn, 24'h203);
    tick();
    chk("b_no_extra", m_roce_bth_valid, 1'b0);
    chk("b_hs_count", 32'(hs_cnt - hs_base), 32'd3);

    // reset after FIRST handshake abandons the transfer
    tick();
    req(32'd2500, 24'h300, 64'h1000);
    hdr("r1", 8'h06, 16'd1024, 24'h300, 1'b1, 1'b0);
    tick();
    chk("r2_op", m_roce_bth_op_code, 8'h07);
    hs_base = hs_cnt;
    done_base = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_valid", m_roce_bth_valid, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_next_psn", next_psn, 24'd0);
    tick(); tick(); tick();
    chk("r_valid_later", m_roce_bth_valid, 1'b0);
    chk("r_no_hs", 32'(hs_cnt - hs_base), 32'd0);
    chk("r_no_done", 32'(done_cnt - done_base), 32'd0);

`ifdef ROCE_SEG_IMMDT_EN
    // immediate data rides on the final packet only
    imm_data = 32'hCAFEF00D;
    req(32'd2500, 24'h400, 64'h2000);
    imm_data = 32'h0;
    hdr("i1", 8'h06, 16'd1024, 24'h400, 1'b1, 1'b0);
    chk("i1_immv", m_roce_immdh_v, 1'b0);
    chk("i1_immd", m_roce_immdh_data, 32'h0);
    tick();
    chk("i2_immv", m_roce_immdh_v, 1'b0);
    tick();
    hdr("i3", 8'h09, 16'd452, 24'h402, 1'b0, 1'b1);
    chk("i3_immv", m_roce_immdh_v, 1'b1);
    chk("i3_immd", m_roce_immdh_data, 32'hCAFEF00D);
    tick();
    chk("i_done", done, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
